mem_bus_ctrl: RTL and testbench

// Physical-side bus controller downstream of the MMU. Accepts one translated word request at a

---
 rtl/mem_bus_ctrl.sv | 103 ++++++++++
 tb/tb_mem_bus_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-outstanding async-SRAM strobe sequencer for the base/ext RAM banks,
// with registered strobes, one-cycle ack and an error ack for unmapped selects.
module mem_bus_ctrl #(
    parameter int RD_WAIT_CYCLES  = 2,
    parameter int WR_PULSE_CYCLES = 2,
    parameter int RAM_ADDR_W      = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mmu_ce_i,
    input  logic [31:0]           mmu_addr_i,
    input  logic [31:0]           mmu_data_i,
    input  logic                  mmu_we_i,
    input  logic [15:0]           mmu_select_i,
    output logic [31:0]           mmu_data_o,
    output logic                  mmu_ack_o,
    output logic                  bus_err_o,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    output logic [31:0]           ram_data_o,
    output logic                  ram_data_oe,
    input  logic [31:0]           base_ram_data_i,
    input  logic [31:0]           ext_ram_data_i,
    output logic                  base_ram_ce_n,
    output logic                  ext_ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n
);
    localparam int MAXC = (RD_WAIT_CYCLES > WR_PULSE_CYCLES) ? RD_WAIT_CYCLES : WR_PULSE_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [2:0] {IDLE, RD_STROBE, WR_SETUP, WR_PULSE, WR_HOLD, ACK, RECOVER} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_bank;
    logic          w_bank, w_accept, w_mapped, w_done, w_strobe, w_unused;
    logic [31:0]   w_rdata;

    assign w_accept = r_state == IDLE && mmu_ce_i && |mmu_select_i;
    assign w_mapped = mmu_select_i == 16'h0001 || mmu_select_i == 16'h0002;
    assign w_done   = r_cnt == '0;
    assign w_bank   = w_accept ? mmu_select_i[1] : r_bank;
    assign w_unused = ^{mmu_addr_i[31:RAM_ADDR_W+2], mmu_addr_i[1:0]};
    assign w_strobe = w_next inside {RD_STROBE, WR_SETUP, WR_PULSE, WR_HOLD};
    // Unmapped reads return zero; writes never touch the read-data register.
    assign w_rdata  = (r_state == RD_STROBE && w_done) ? (r_bank ? ext_ram_data_i : base_ram_data_i) :
                      (w_accept && !w_mapped && !mmu_we_i) ? '0 : mmu_data_o;

    always_comb begin
        w_next = r_state;
        w_cnt  = w_done ? r_cnt : r_cnt - CW'(1);
        case (r_state)
            IDLE: if (w_accept) begin
                w_next = !w_mapped ? ACK : mmu_we_i ? WR_SETUP : RD_STROBE;
                w_cnt  = CW'(RD_WAIT_CYCLES - 1);
            end
            RD_STROBE: w_next = w_done ? ACK : RD_STROBE;
            WR_SETUP: begin
                w_next = WR_PULSE;
                w_cnt  = CW'(WR_PULSE_CYCLES - 1);
            end
            WR_PULSE: w_next = w_done ? WR_HOLD : WR_PULSE;
            WR_HOLD:  w_next = ACK;
            ACK:      w_next = RECOVER;
            default:  w_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bank        <= 1'b0;
            ram_addr_o    <= '0;
            ram_data_o    <= '0;
            base_ram_ce_n <= 1'b1;
            ext_ram_ce_n  <= 1'b1;
            ram_oe_n      <= 1'b1;
            ram_we_n      <= 1'b1;
            ram_data_oe   <= 1'b0;
            mmu_ack_o     <= 1'b0;
            bus_err_o     <= 1'b0;
            mmu_data_o    <= '0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= w_cnt;
            r_bank        <= w_bank;
            if (w_accept) begin
                ram_addr_o <= mmu_addr_i[RAM_ADDR_W+1:2];
                ram_data_o <= mmu_data_i;
            end
            base_ram_ce_n <= !(w_strobe && !w_bank);
            ext_ram_ce_n  <= !(w_strobe && w_bank);
            ram_oe_n      <= w_next != RD_STROBE;
            ram_we_n      <= w_next != WR_PULSE;
            ram_data_oe   <= w_strobe && w_next != RD_STROBE;
            mmu_ack_o     <= w_next == ACK;
            bus_err_o     <= w_next == ACK && r_state == IDLE;
            mmu_data_o    <= w_rdata;
        end
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed checks of mem_bus_ctrl with default timing (dut_a)
// and RD_WAIT_CYCLES=1 / WR_PULSE_CYCLES=4 (dut_b).
module tb_mem_bus_ctrl;
    logic        clk = 0, rst = 0, ce_a = 0, ce_b = 0, we_i = 0;
    logic [15:0] sel_i = 0;
    logic [31:0] addr_i = 0, wdata_i = 0, base_d = 0, ext_d = 0;
    logic [31:0] a_data, b_data, a_wd, b_wd;
    logic [19:0] a_addr, b_addr;
    logic        a_ack, a_err, a_doe, a_bce, a_ece, a_oe, a_we;
    logic        b_ack, b_err, b_doe, b_bce, b_ece, b_oe, b_we;
    bit          sel_b = 0;
    int          n_checks = 0, n_fail = 0;

    int          lat, we_low;
    bit          viol, base_seen, ext_seen, oe_seen, ack2;
    logic [31:0] rdata, wd_seen;
    logic [19:0] addr_seen;
    logic        err;

    wire        m_ack = sel_b ? b_ack : a_ack;
    wire        m_err = sel_b ? b_err : a_err;
    wire [31:0] m_data = sel_b ? b_data : a_data;
    wire [31:0] m_wd = sel_b ? b_wd : a_wd;
    wire [19:0] m_addr = sel_b ? b_addr : a_addr;
    wire        m_doe = sel_b ? b_doe : a_doe;
    wire        m_bce = sel_b ? b_bce : a_bce;
    wire        m_ece = sel_b ? b_ece : a_ece;
    wire        m_oe = sel_b ? b_oe : a_oe;
    wire        m_we = sel_b ? b_we : a_we;

    always #5 clk = ~clk;

    mem_bus_ctrl dut_a (
        .clk(clk), .rst(rst), .mmu_ce_i(ce_a), .mmu_addr_i(addr_i), .mmu_data_i(wdata_i),
        .mmu_we_i(we_i), .mmu_select_i(sel_i), .mmu_data_o(a_data), .mmu_ack_o(a_ack),
        .bus_err_o(a_err), .ram_addr_o(a_addr), .ram_data_o(a_wd), .ram_data_oe(a_doe),
        .base_ram_data_i(base_d), .ext_ram_data_i(ext_d), .base_ram_ce_n(a_bce),
        .ext_ram_ce_n(a_ece), .ram_oe_n(a_oe), .ram_we_n(a_we)
    );

    mem_bus_ctrl #(.RD_WAIT_CYCLES(1), .WR_PULSE_CYCLES(4), .RAM_ADDR_W(20)) dut_b (
        .clk(clk), .rst(rst), .mmu_ce_i(ce_b), .mmu_addr_i(addr_i), .mmu_data_i(wdata_i),
        .mmu_we_i(we_i), .mmu_select_i(sel_i), .mmu_data_o(b_data), .mmu_ack_o(b_ack),
        .bus_err_o(b_err), .ram_addr_o(b_addr), .ram_data_o(b_wd), .ram_data_oe(b_doe),
        .base_ram_data_i(base_d), .ext_ram_data_i(ext_d), .base_ram_ce_n(b_bce),
        .ext_ram_ce_n(b_ece), .ram_oe_n(b_oe), .ram_we_n(b_we)
    );

    // Issues one request (called just after a negedge), drops ce after the accept edge and
    // records latency in cycles, strobe activity and ack-time values; then waits out RECOVER.
    task automatic run_req(input bit b, input bit we, input logic [15:0] sel,
                           input logic [31:0] addr, input logic [31:0] data);
        sel_b = b; we_i = we; sel_i = sel; addr_i = addr; wdata_i = data;
        if (b) ce_b = 1; else ce_a = 1;
        @(posedge clk); #1;
        ce_a = 0; ce_b = 0;
        lat = -1; we_low = 0; viol = 0; base_seen = 0; ext_seen = 0; oe_seen = 0; ack2 = 0;
        addr_seen = '1; wd_seen = '1; rdata = 'x; err = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if ((!m_bce || !m_ece) && !base_seen && !ext_seen) begin addr_seen = m_addr; wd_seen = m_wd; end
            if (!m_bce) base_seen = 1;
            if (!m_ece) ext_seen = 1;
            if (!m_oe) oe_seen = 1;
            if (!m_we) we_low++;
            if ((!m_bce && !m_ece) || (!m_we && (!m_doe || (m_bce && m_ece))) || (!m_oe && !m_we)) viol = 1;
            if (m_ack) begin lat = k; rdata = m_data; err = m_err; break; end
        end
        repeat (3) begin
            @(negedge clk);
            if (m_ack) ack2 = 1;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1;
        #2;
        n_checks++; if ({a_bce, a_ece, a_oe, a_we, a_doe} !== 5'b11110) begin n_fail++; $display("FAIL reset_strobes_a got=%b exp=11110", {a_bce, a_ece, a_oe, a_we, a_doe}); end
        n_checks++; if ({b_bce, b_ece, b_oe, b_we, b_doe} !== 5'b11110) begin n_fail++; $display("FAIL reset_strobes_b got=%b exp=11110", {b_bce, b_ece, b_oe, b_we, b_doe}); end
        n_checks++; if ({a_ack, a_err, b_ack, b_err} !== 4'b0) begin n_fail++; $display("FAIL reset_ack_err got=%b exp=0000", {a_ack, a_err, b_ack, b_err}); end
        n_checks++; if ({a_data, a_wd, a_addr} !== '0) begin n_fail++; $display("FAIL reset_data_addr got=%h/%h/%h exp=0", a_data, a_wd, a_addr); end
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        n_checks++; if ({a_bce, a_ece, a_oe, a_we, a_doe, a_ack} !== 6'b111100) begin n_fail++; $display("FAIL idle_after_reset got=%b exp=111100", {a_bce, a_ece, a_oe, a_we, a_doe, a_ack}); end
    endtask

    task automatic test_read_base();
        base_d = 32'hDEADBEEF; ext_d = 32'h55555555;
        run_req(0, 0, 16'h0001, 32'h0000_0010, 32'h0);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL read_latency got=%0d exp=3", lat); end
        n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data got=%h exp=deadbeef", rdata); end
        n_checks++; if (addr_seen !== 20'h4) begin n_fail++; $display("FAIL read_addr got=%h exp=4", addr_seen); end
        n_checks++; if ({base_seen, ext_seen, oe_seen, err, viol} !== 5'b10100) begin n_fail++; $display("FAIL read_strobes got=%b exp=10100", {base_seen, ext_seen, oe_seen, err, viol}); end
        n_checks++; if (we_low !== 0) begin n_fail++; $display("FAIL read_we_low got=%0d exp=0", we_low); end
        n_checks++; if (ack2 !== 0) begin n_fail++; $display("FAIL read_ack_twice got=%b exp=0", ack2); end
        base_d = 32'h0;
        n_checks++; if (m_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data_hold got=%h exp=deadbeef", m_data); end
    endtask

    task automatic test_write_ext();
        run_req(0, 1, 16'h0002, 32'h0040_0008, 32'h12345678);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL write_latency got=%0d exp=5", lat); end
        n_checks++; if (we_low !== 2) begin n_fail++; $display("FAIL write_we_cycles got=%0d exp=2", we_low); end
        n_checks++; if (addr_seen !== 20'h2) begin n_fail++; $display("FAIL write_addr got=%h exp=2", addr_seen); end
        n_checks++; if (wd_seen !== 32'h12345678) begin n_fail++; $display("FAIL write_bus_data got=%h exp=12345678", wd_seen); end
        n_checks++; if ({base_seen, ext_seen, oe_seen, err, viol} !== 5'b01000) begin n_fail++; $display("FAIL write_strobes got=%b exp=01000", {base_seen, ext_seen, oe_seen, err, viol}); end
        n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_keeps_rdata got=%h exp=deadbeef", rdata); end
    endtask

    task automatic test_unmapped();
        run_req(0, 0, 16'h0004, 32'h0000_0100, 32'h0);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL unmapped4_latency got=%0d exp=1", lat); end
        n_checks++; if ({err, base_seen, ext_seen, oe_seen} !== 4'b1000) begin n_fail++; $display("FAIL unmapped4_err_strobes got=%b exp=1000", {err, base_seen, ext_seen, oe_seen}); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped4_data got=%h exp=0", rdata); end
        base_d = 32'hA5A5A5A5;
        run_req(0, 0, 16'h0001, 32'h0000_0020, 32'h0);
        n_checks++; if (rdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL reread_data got=%h exp=a5a5a5a5", rdata); end
        run_req(0, 0, 16'h0003, 32'h0000_0020, 32'h0);
        n_checks++; if ({lat == 1, err, base_seen, ext_seen} !== 4'b1100) begin n_fail++; $display("FAIL multihot lat=%0d err/strobes got=%b exp=1100", lat, {err, base_seen, ext_seen}); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL multihot_data got=%h exp=0", rdata); end
        run_req(0, 1, 16'h8000, 32'h0000_0030, 32'hFFFF0000);
        n_checks++; if ({lat == 1, err, base_seen, ext_seen, we_low == 0} !== 5'b11001) begin n_fail++; $display("FAIL unmapped_write lat=%0d got=%b exp=11001", lat, {err, base_seen, ext_seen, we_low == 0}); end
        sel_b = 0; sel_i = 16'h0; we_i = 0; ce_a = 1;
        begin
            bit act = 0;
            repeat (6) begin
                @(negedge clk);
                if (a_ack || !a_bce || !a_ece) act = 1;
            end
            ce_a = 0;
            n_checks++; if (act !== 0) begin n_fail++; $display("FAIL zero_select_accepted got=%b exp=0", act); end
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0, ackpos = -1, gap = -1;
        bit prev = 0, dbl = 0;
        sel_b = 0; base_d = 32'h0BADF00D; sel_i = 16'h0001; we_i = 0; addr_i = 32'h44; ce_a = 1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (a_ack && prev) dbl = 1;
            prev = a_ack;
            if (a_ack) begin acks++; if (acks == 1) ackpos = k; end
            if (acks == 1 && k > ackpos && gap < 0 && !a_bce) gap = k - ackpos;
            if (acks == 2) break;
        end
        ce_a = 0;
        n_checks++; if (acks !== 2) begin n_fail++; $display("FAIL b2b_acks got=%0d exp=2", acks); end
        n_checks++; if (gap !== 3) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=3", gap); end
        n_checks++; if (dbl !== 0) begin n_fail++; $display("FAIL b2b_double_ack got=%b exp=0", dbl); end
        n_checks++; if (a_data !== 32'h0BADF00D) begin n_fail++; $display("FAIL b2b_data got=%h exp=0badf00d", a_data); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_params_b();
        ext_d = 32'hCAFE0001;
        run_req(1, 0, 16'h0002, 32'h0000_0008, 32'h0);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL b_read_latency got=%0d exp=2", lat); end
        n_checks++; if ({rdata, addr_seen} !== {32'hCAFE0001, 20'h2}) begin n_fail++; $display("FAIL b_read_data got=%h@%h exp=cafe0001@2", rdata, addr_seen); end
        run_req(1, 1, 16'h0001, 32'h0000_000C, 32'h0F0F0F0F);
        n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL b_write_latency got=%0d exp=7", lat); end
        n_checks++; if (we_low !== 4) begin n_fail++; $display("FAIL b_write_we_cycles got=%0d exp=4", we_low); end
        n_checks++; if ({wd_seen, viol, oe_seen} !== {32'h0F0F0F0F, 2'b00}) begin n_fail++; $display("FAIL b_write_bus got=%h viol/oe=%b exp=0f0f0f0f/00", wd_seen, {viol, oe_seen}); end
        sel_b = 0;
    endtask

    task automatic test_reset_mid_write();
        bit late_ack = 0;
        sel_b = 0; we_i = 1; sel_i = 16'h0001; addr_i = 32'h20; wdata_i = 32'h77777777; ce_a = 1;
        @(posedge clk); #1 ce_a = 0;
        for (int k = 0; k < 10 && a_we; k++) @(negedge clk);
        n_checks++; if (a_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_reach_pulse got=%b exp=0", a_we); end
        #2 rst = 1;
        #1;
        n_checks++; if ({a_bce, a_ece, a_oe, a_we, a_doe} !== 5'b11110) begin n_fail++; $display("FAIL rst_mid_strobes got=%b exp=11110", {a_bce, a_ece, a_oe, a_we, a_doe}); end
        @(negedge clk) rst = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_ack) late_ack = 1;
        end
        n_checks++; if (late_ack !== 0) begin n_fail++; $display("FAIL rst_mid_ack got=%b exp=0", late_ack); end
    endtask

    initial begin
        test_reset();
        test_read_base();
        test_write_ext();
        test_unmapped();
        test_back_to_back();
        test_params_b();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
